// File: rtl/mc_pkg.sv
// mc_pkg: shared stage encoding and decoder control constants for the multi-cycle datapath
package mc_pkg;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [2:0] ALUOP_ADD = 3'b000;
  localparam logic [2:0] ALUOP_SUB = 3'b001;
  localparam logic [2:0] ALUOP_OR  = 3'b010;
  localparam logic [2:0] ALUOP_AND = 3'b011;
  localparam logic [2:0] ALUOP_LUI = 3'b100;
  localparam logic [2:0] ALUOP_SLT = 3'b101;
  localparam logic [1:0] REGDES_RT   = 2'b00;
  localparam logic [1:0] REGDES_RD   = 2'b01;
  localparam logic [1:0] REGDES_ZERO = 2'b10;
  localparam logic [1:0] REGDES_RA   = 2'b11;
  localparam logic [1:0] REGDATA_MEM  = 2'b00;
  localparam logic [1:0] REGDATA_ALU  = 2'b01;
  localparam logic [1:0] REGDATA_ZERO = 2'b10;
  localparam logic [1:0] REGDATA_PC4  = 2'b11;
  localparam logic [2:0] NPC_PC4 = 3'b000;
  localparam logic [2:0] NPC_BEQ = 3'b001;
  localparam logic [2:0] NPC_J   = 3'b010;
  localparam logic [2:0] NPC_JR  = 3'b011;
endpackage

// File: rtl/mc_stage_fsm.sv
// mc_stage_fsm: stage sequencer with registered imem/dmem requests, handshake strobes and memory watchdog
module mc_stage_fsm
  import mc_pkg::*;
#(
  parameter int MEM_LAT_MAX = 64
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   imem_ready,
  input  logic   dmem_ready,
  input  logic   dmRE,
  input  logic   dmWE,
  input  logic   regWE,
  output state_t state,
  output logic   imem_req,
  output logic   dmem_req,
  output logic   fetch_done,
  output logic   mem_done,
  output logic   timeout_err
);
  logic [31:0] wd_cnt;
  logic waiting, expire;
  assign fetch_done = imem_req && imem_ready;
  assign mem_done = dmem_req && dmem_ready;
  assign waiting = (imem_req && !imem_ready) || (dmem_req && !dmem_ready);
  assign expire = MEM_LAT_MAX != 0 && waiting && wd_cnt == 32'(MEM_LAT_MAX - 1);
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_FETCH;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      wd_cnt <= '0;
      timeout_err <= 1'b0;
    end else if (expire) begin
      state <= S_HALT;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      timeout_err <= 1'b1;
    end else begin
      wd_cnt <= waiting ? wd_cnt + 32'd1 : '0;
      case (state)
        S_FETCH: begin
          imem_req <= !fetch_done;
          if (fetch_done) state <= S_DECODE;
        end
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          state <= (dmRE || dmWE) ? S_MEM : regWE ? S_WB : S_FETCH;
          dmem_req <= dmRE || dmWE;
          imem_req <= !(dmRE || dmWE || regWE);
        end
        S_MEM: begin
          dmem_req <= !mem_done;
          if (mem_done) begin
            state <= regWE ? S_WB : S_FETCH;
            imem_req <= !regWE;
          end
        end
        S_WB: begin
          state <= S_FETCH;
          imem_req <= 1'b1;
        end
        default: begin
          imem_req <= 1'b0;
          dmem_req <= 1'b0;
        end
      endcase
    end
endmodule

// File: rtl/mc_datapath.sv
// mc_datapath: multi-cycle MIPS-subset datapath; decoder controls in, IR out, req/ready IM and DM ports, wb_* trace, sticky timeout_err
module mc_datapath
  import mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int MEM_LAT_MAX = 64,
  parameter bit TRACE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  aluCtrl,
  input  logic [1:0]  regDesCtrl,
  input  logic [1:0]  regDataCtrl,
  input  logic [2:0]  nextPCop,
  input  logic        aluSrc,
  input  logic        usExt,
  input  logic        regWE,
  input  logic        dmWE,
  input  logic        dmRE,
  output logic [31:0] instr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_pc,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        timeout_err
);
  state_t state;
  logic fetch_done, mem_done;
  logic [31:0] ir, pc, pc4, a, b, alu_out, mdr, ext, bsrc, alu_y, npc, wd;
  logic [31:0] gpr [32];
  logic [15:0] imm;
  logic [4:0] dst;
  mc_stage_fsm #(.MEM_LAT_MAX(MEM_LAT_MAX)) u_fsm (
    .clk(clk), .reset(reset), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .dmRE(dmRE), .dmWE(dmWE), .regWE(regWE), .state(state), .imem_req(imem_req),
    .dmem_req(dmem_req), .fetch_done(fetch_done), .mem_done(mem_done), .timeout_err(timeout_err)
  );
  assign imm = ir[15:0];
  assign ext = usExt ? {16'b0, imm} : {{16{imm[15]}}, imm};
  assign bsrc = aluSrc ? ext : b;
  assign alu_y = aluCtrl == ALUOP_ADD ? a + bsrc :
                 aluCtrl == ALUOP_SUB ? a - bsrc :
                 aluCtrl == ALUOP_OR  ? a | bsrc :
                 aluCtrl == ALUOP_AND ? a & bsrc :
                 aluCtrl == ALUOP_LUI ? bsrc << 16 :
                 aluCtrl == ALUOP_SLT ? {31'b0, $signed(a) < $signed(bsrc)} : '0;
  assign npc = nextPCop == NPC_BEQ ? (a == b ? pc4 + {{14{imm[15]}}, imm, 2'b00} : pc4) :
               nextPCop == NPC_J   ? {pc4[31:28], ir[25:0], 2'b00} :
               nextPCop == NPC_JR  ? a : pc4;
  assign dst = regDesCtrl == REGDES_RT ? ir[20:16] :
               regDesCtrl == REGDES_RD ? ir[15:11] :
               regDesCtrl == REGDES_ZERO ? 5'd0 : 5'd31;
  assign wd = regDataCtrl == REGDATA_MEM ? mdr :
              regDataCtrl == REGDATA_ALU ? alu_out :
              regDataCtrl == REGDATA_ZERO ? '0 : pc4;
  always_ff @(posedge clk)
    if (reset) begin
      pc <= RESET_PC;
      ir <= '0;
      pc4 <= '0;
      a <= '0;
      b <= '0;
      alu_out <= '0;
      mdr <= '0;
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
    end else begin
      if (fetch_done) begin
        ir <= imem_rdata;
        pc4 <= pc + 32'd4;
      end
      if (state == S_DECODE) begin
        a <= gpr[ir[25:21]];
        b <= gpr[ir[20:16]];
      end
      if (state == S_EXEC) begin
        alu_out <= alu_y;
        pc <= npc;
      end
      if (mem_done && !dmWE) mdr <= dmem_rdata;
      if (state == S_WB && dst != 5'd0) gpr[dst] <= wd;
    end
  assign instr = ir;
  assign imem_addr = pc;
  assign dmem_we = dmem_req && dmWE;
  assign dmem_addr = {alu_out[31:2], 2'b00};
  assign dmem_wdata = b;
  assign wb_valid = TRACE_EN && state == S_WB;
  assign wb_pc = wb_valid ? pc4 - 32'd4 : '0;
  assign wb_reg = wb_valid ? dst : '0;
  assign wb_data = wb_valid ? wd : '0;
endmodule

// File: tb/tb_mc_datapath.sv
// tb_mc_datapath: directed program run against mc_datapath with a bench-side decoder, IM/DM responders and a write-back scoreboard
module tb_mc_datapath;
  import mc_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] aluCtrl, nextPCop;
  logic [1:0] regDesCtrl, regDataCtrl;
  logic aluSrc, usExt, regWE, dmWE, dmRE;
  logic [31:0] instr, imem_addr, dmem_addr, dmem_wdata, wb_pc, wb_data;
  logic [31:0] imem_rdata = '0;
  logic [31:0] dmem_rdata = '0;
  logic imem_ready = 1'b0;
  logic dmem_ready = 1'b0;
  logic imem_req, dmem_req, dmem_we, wb_valid, timeout_err;
  logic [4:0] wb_reg;
  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  typedef struct {logic [31:0] pc; logic [4:0] rg; logic [31:0] d;} wb_t;
  wb_t exp_q[$];
  wb_t e;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mc_datapath #(.MEM_LAT_MAX(4)) dut (
    .clk(clk), .reset(reset), .aluCtrl(aluCtrl), .regDesCtrl(regDesCtrl), .regDataCtrl(regDataCtrl),
    .nextPCop(nextPCop), .aluSrc(aluSrc), .usExt(usExt), .regWE(regWE), .dmWE(dmWE), .dmRE(dmRE),
    .instr(instr), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_pc(wb_pc), .wb_reg(wb_reg), .wb_data(wb_data), .timeout_err(timeout_err)
  );
  always_comb begin
    aluCtrl = ALUOP_ADD;
    nextPCop = NPC_PC4;
    regDesCtrl = REGDES_RT;
    regDataCtrl = REGDATA_MEM;
    aluSrc = 1'b0;
    usExt = 1'b0;
    regWE = 1'b0;
    dmWE = 1'b0;
    dmRE = 1'b0;
    case (instr[31:26])
      6'h0d: begin aluSrc = 1'b1; usExt = 1'b1; aluCtrl = ALUOP_OR; regWE = 1'b1; regDataCtrl = REGDATA_ALU; end
      6'h0f: begin aluSrc = 1'b1; aluCtrl = ALUOP_LUI; regWE = 1'b1; regDataCtrl = REGDATA_ALU; end
      6'h23: begin aluSrc = 1'b1; dmRE = 1'b1; regWE = 1'b1; end
      6'h2b: begin aluSrc = 1'b1; dmWE = 1'b1; end
      6'h04: begin aluCtrl = ALUOP_SUB; nextPCop = NPC_BEQ; end
      6'h02: nextPCop = NPC_J;
      6'h03: begin nextPCop = NPC_J; regWE = 1'b1; regDesCtrl = REGDES_RA; regDataCtrl = REGDATA_PC4; end
      6'h00:
        case (instr[5:0])
          6'h08: begin nextPCop = NPC_JR; regWE = 1'b1; regDesCtrl = REGDES_ZERO; regDataCtrl = REGDATA_ZERO; end
          6'h21: begin regWE = 1'b1; regDesCtrl = REGDES_RD; regDataCtrl = REGDATA_ALU; end
          6'h2a: begin aluCtrl = ALUOP_SLT; regWE = 1'b1; regDesCtrl = REGDES_RD; regDataCtrl = REGDATA_ALU; end
          default: ;
        endcase
      default: ;
    endcase
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (wb_valid) begin
      if (exp_q.size() == 0) check("wb_spurious", {31'b0, wb_valid}, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("wb_pc", wb_pc, e.pc);
        check("wb_reg", {27'b0, wb_reg}, {27'b0, e.rg});
        check("wb_data", wb_data, e.d);
      end
    end
  task automatic expect_wb(input logic [31:0] pc, input logic [4:0] rg, input logic [31:0] d);
    exp_q.push_back('{pc, rg, d});
  endtask
  task automatic run(input logic [31:0] pc, input logic [31:0] ins, input int iw, input int lat,
                     input bit m = 1'b0, input int dw = 0, input logic [31:0] da = '0,
                     input logic [31:0] dd = '0, input logic dwe = 1'b0);
    int n, t0, dn;
    n = 0;
    while (!imem_req && n < 20) begin @(negedge clk); n++; end
    check("fetch_req", {31'b0, imem_req}, 32'd1);
    check("fetch_pc", imem_addr, pc);
    t0 = cyc;
    repeat (iw) @(negedge clk);
    imem_ready = 1'b1;
    imem_rdata = ins;
    @(negedge clk);
    imem_ready = 1'b0;
    n = 0;
    dn = 0;
    while (!imem_req && n < 30) begin
      if (dmem_req) begin
        if (dn == 0) begin
          check("dmem_addr", dmem_addr, da);
          check("dmem_we", {31'b0, dmem_we}, {31'b0, dwe});
          if (dwe) check("dmem_wdata", dmem_wdata, dd);
        end
        dmem_ready = dn == dw;
        dmem_rdata = dd;
        dn++;
      end
      @(negedge clk);
      dmem_ready = 1'b0;
      n++;
    end
    check("dmem_req_cycles", 32'(dn), m ? 32'(dw + 1) : 32'd0);
    check("latency", 32'(cyc - t0), 32'(lat));
  endtask
  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_imem_addr", imem_addr, 32'h3000);
    check("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("rst_timeout", {31'b0, timeout_err}, 32'd0);
    check("rst_instr", instr, 32'd0);
    reset = 1'b0;
    expect_wb(32'h3000, 5'd1, 32'h0000_1234);
    run(32'h3000, 32'h3401_1234, 0, 4);
    expect_wb(32'h3004, 5'd2, 32'hDEAD_BEEF);
    run(32'h3004, 32'h8C02_0004, 0, 8, 1'b1, 3, 32'h4, 32'hDEAD_BEEF, 1'b0);
    run(32'h3008, 32'h1021_FFFF, 1, 4);
    run(32'h3008, 32'h1022_FFFF, 0, 3);
    expect_wb(32'h300C, 5'd3, 32'hDEAD_D123);
    run(32'h300C, 32'h0022_1821, 0, 4);
    expect_wb(32'h3010, 5'd31, 32'h3014);
    run(32'h3010, 32'h0C00_0C10, 0, 4);
    run(32'h3040, 32'hAC23_0008, 0, 4, 1'b1, 0, 32'h123C, 32'hDEAD_D123, 1'b1);
    expect_wb(32'h3044, 5'd4, 32'h1);
    run(32'h3044, 32'h0041_202A, 0, 4);
    expect_wb(32'h3048, 5'd5, 32'h8000_0000);
    run(32'h3048, 32'h3C05_8000, 0, 4);
    expect_wb(32'h304C, 5'd0, 32'h5);
    run(32'h304C, 32'h3400_0005, 0, 4);
    expect_wb(32'h3050, 5'd6, 32'h1234);
    run(32'h3050, 32'h0001_3021, 0, 4);
    expect_wb(32'h3054, 5'd0, 32'h0);
    run(32'h3054, 32'h03E0_0008, 0, 4);
    run(32'h3014, 32'h0800_0C18, 0, 3);
    check("halt_pc", imem_addr, 32'h3060);
    for (int i = 0; i < 4; i++) begin
      check("wd_pending_err", {31'b0, timeout_err}, 32'd0);
      check("wd_pending_req", {31'b0, imem_req}, 32'd1);
      @(negedge clk);
    end
    check("wd_timeout_err", {31'b0, timeout_err}, 32'd1);
    check("wd_req_drop", {31'b0, imem_req}, 32'd0);
    repeat (3) @(negedge clk);
    check("halt_sticky_err", {31'b0, timeout_err}, 32'd1);
    check("halt_req", {31'b0, imem_req}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst2_err", {31'b0, timeout_err}, 32'd0);
    check("rst2_req", {31'b0, imem_req}, 32'd0);
    check("rst2_pc", imem_addr, 32'h3000);
    n = 0;
    while (!imem_req && n < 20) begin @(negedge clk); n++; end
    check("t6_fetch_req", {31'b0, imem_req}, 32'd1);
    imem_ready = 1'b1;
    imem_rdata = 32'h8C07_0000;
    @(negedge clk);
    imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_in_mem", {31'b0, dmem_req}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_req_drop", {31'b0, dmem_req}, 32'd0);
    reset = 1'b0;
    dmem_ready = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    dmem_ready = 1'b0;
    check("t6_req_after", {31'b0, dmem_req}, 32'd0);
    check("t6_pc", imem_addr, 32'h3000);
    check("t6_instr", instr, 32'd0);
    expect_wb(32'h3000, 5'd8, 32'h0);
    run(32'h3000, 32'h0020_4021, 0, 4);
    check("wb_pending", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
